disparo_inimigo: RTL and testbench
==================================

Name: disparo_inimigo

Overview:
- Fires the enemy projectile. The shot spawns under the enemy, falls toward the player ship and detects hits on the ship. It also tracks player lives.
- It is the return path of the allied shot: allied ball goes up and hits the enemy; this block's ball goes down and hits the ship.
- Sits beside nave/inimigo/bola in the entities level. Its outputs replace the constant enemy-ball coordinates feeding the renderer.

Parameters:
- TICK_DIV, 250000: CLOCK_50 cycles per movement step (200 Hz).
- PASSO, 2: pixels added to y per step.
- COOLDOWN, 100: steps spent in ESPERA between shots.
- RAIO, 5: ball radius in pixels.
- Y_LIMITE, 480: screen bottom; the ball is retired at or past this row.
- VIDAS_INI, 3: lives after reset or restart.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- pausa  in  1  high freezes all state.
- reiniciarJogo  in  1  synchronous restart, equivalent to reset.
- inimigo_vivo  in  1  enemy may fire.
- x_inimigo, y_inimigo  in  10 each  enemy top-left corner.
- largura_inimigo, altura_inimigo  in  10 each  enemy size.
- x_nave, y_nave  in  10 each  ship top-left corner.
- largura_nave, altura_nave  in  10 each  ship size.
- x_bola_inimiga, y_bola_inimiga  out  10 each  ball center.
- raio_bola_inimiga  out  10  constant RAIO.
- bola_ativa  out  1  ball visible/in flight.
- nave_atingida  out  1  one-cycle pulse on hit.
- vidas  out  2  lives remaining.
- fim_de_jogo  out  1  high when lives reach 0.

Behaviour:
- Reset (asynchronous, reset=0):
  - State ESPERA, tick counter 0, cooldown counter 0.
  - x/y outputs 0, bola_ativa 0, nave_atingida 0, vidas VIDAS_INI, fim_de_jogo 0.
- reiniciarJogo=1 at a clock edge gives the same values. It has highest synchronous priority, above pausa.
- Tick: counter runs 0..TICK_DIV-1; tick=1 for the one cycle where the counter equals TICK_DIV-1, then the counter wraps. Counter holds while pausa=1.
- pausa=1: no state, counter or output changes. No collision is evaluated, and nave_atingida stays 0.
- ESPERA:
  - Each tick, cooldown increments while below COOLDOWN.
  - At cooldown==COOLDOWN with inimigo_vivo=1, on the next tick: latch x = x_inimigo + largura_inimigo/2 and y = y_inimigo + altura_inimigo (10-bit sums, truncated).
  - On that launch: bola_ativa=1, cooldown=0, go to ATIVA.
  - If inimigo_vivo=0, cooldown saturates at COOLDOWN and the block waits.
- ATIVA:
  - Each tick, y += PASSO. x is unchanged (see the optional feature).
  - Launch coordinates are latched; the ball does not follow the enemy.
  - The enemy dying mid-flight does not cancel the ball.
- Collision, evaluated every non-paused cycle in ATIVA, all compares 11-bit (no wrap):
  - x_nave <= x < x_nave+largura_nave, and
  - y+RAIO >= y_nave, and
  - y < y_nave+altura_nave.
- On collision:
  - Go to ACERTO, bola_ativa=0, x=y=0.
- Out of screen: a tick where y+PASSO >= Y_LIMITE sets bola_ativa=0 and x=y=0, and returns to ESPERA with no life lost.
  - If collision and out-of-screen occur in the same cycle, collision wins.
- ACERTO (one cycle):
  - nave_atingida=1 and vidas decrements.
  - If new vidas==0, go to FIM and set fim_de_jogo=1; otherwise go to ESPERA with cooldown=0.
- FIM: absorbing state; bola_ativa=0. Only reset or reiniciarJogo exits it.
- vidas never underflows, since decrements occur only from ACERTO with vidas >= 1.
- raio_bola_inimiga is always RAIO, including in reset.
- Outputs are registered; coordinates change one cycle after the tick.

Optional Feature:
- Macro MIRA_EN.
- Defined:
  - At launch, latch alvo = x_nave + largura_nave/2.
  - Each ATIVA tick, x moves 1 pixel toward alvo (+1 if x<alvo, -1 if x>alvo, 0 if equal), in parallel with the y step.
- Undefined: x is constant in flight and no alvo register exists.

Decomposition:
- Package pkg_jogo:
  - Screen constants LARGURA_TELA=640, ALTURA_TELA=480.
  - State encoding ESPERA=2'd0, ATIVA=2'd1, ACERTO=2'd2, FIM=2'd3.
  - Default VIDAS_INI.
- Sub-module divisor_tick (TICK_DIV parameter, pausa hold, tick output); reusable by nave/inimigo/bola.
- FSM, collision and lives logic stay in disparo_inimigo.

Test Plan (TICK_DIV=4, COOLDOWN=2, PASSO=2):
- Launch: reset low then high, inimigo_vivo=1, enemy (20,40) size 40x20. Required: bola_ativa=1 at (40,60) after 3 ticks; y=62 one tick later.
- Miss and retire: ship at (300,400). Required: ball reaches y>=478; at y=478 the next tick gives bola_ativa=0, x=y=0, vidas=3, nave_atingida never asserted.
- Hit: ship at (30,100) 40x20. Required: when y+5 >= 100, nave_atingida is high for exactly 1 cycle, vidas 3->2, then ESPERA.
- Game over: three hits. Required: vidas=0, fim_de_jogo=1, no further launches for 50 ticks. Then reiniciarJogo pulse gives vidas=3, fim_de_jogo=0.
- Pause/reset: pausa=1 for 20 cycles mid-flight gives unchanged y. reset low mid-flight asynchronously clears bola_ativa and restores vidas=3 without waiting for a clock.
- MIRA_EN: ship center at 100, launch x=40. Required: after 5 ticks x=45; x holds at 100 once reached.

Source files
------------

// File: rtl/disparo_inimigo_pkg.sv
// Shared game-level definitions for the entities layer (package pkg_jogo):
// screen size, enemy-shot FSM encoding, default life count and a small
// helper that computes the horizontal center of a sprite.
package pkg_jogo;

    localparam int LARGURA_TELA     = 640;
    localparam int ALTURA_TELA      = 480;
    localparam int VIDAS_INI_PADRAO = 3;

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        ATIVA  = 2'd1,
        ACERTO = 2'd2,
        FIM    = 2'd3
    } estado_t;

    // Horizontal center of a sprite: left edge plus half its width, 10-bit truncated.
    function automatic logic [9:0] centro(input logic [9:0] pos, input logic [9:0] tam);
        return pos + {1'b0, tam[9:1]};
    endfunction

endpackage

// File: rtl/disparo_inimigo_divisor_tick.sv
// Movement-step divider: counts 0..TICK_DIV-1 and flags the last count as
// a one-cycle tick. The count freezes while pausa is high and restarts on
// either the async reset or the synchronous restart.
module divisor_tick #(
    parameter int TICK_DIV = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic pausa,
    output logic tick
);

    localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: hold while paused, wrap after the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (pausa) begin
            cnt_d = cnt_q;
        end else if (cnt_q == ULTIMO) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with async reset and synchronous restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == ULTIMO);

endmodule

// File: rtl/disparo_inimigo.sv
// Enemy projectile: spawns under the enemy after a cooldown, falls toward
// the player ship, detects hits and tracks the player's lives.
// Optional macro MIRA_EN: the ball also drifts 1 px per step toward the
// ship's center as latched at launch.
module disparo_inimigo
    import pkg_jogo::*;
#(
    parameter int TICK_DIV  = 250000,
    parameter int PASSO     = 2,
    parameter int COOLDOWN  = 100,
    parameter int RAIO      = 5,
    parameter int Y_LIMITE  = ALTURA_TELA,
    parameter int VIDAS_INI = VIDAS_INI_PADRAO
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pausa,
    input  logic       reiniciarJogo,
    input  logic       inimigo_vivo,
    input  logic [9:0] x_inimigo,
    input  logic [9:0] y_inimigo,
    input  logic [9:0] largura_inimigo,
    input  logic [9:0] altura_inimigo,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic [9:0] largura_nave,
    input  logic [9:0] altura_nave,
    output logic [9:0] x_bola_inimiga,
    output logic [9:0] y_bola_inimiga,
    output logic [9:0] raio_bola_inimiga,
    output logic       bola_ativa,
    output logic       nave_atingida,
    output logic [1:0] vidas,
    output logic       fim_de_jogo
);

    localparam int             CDW      = $clog2(COOLDOWN + 2);
    localparam logic [CDW-1:0] CD_MAX   = CDW'(COOLDOWN);
    localparam logic [1:0]     VIDAS_RST = 2'(VIDAS_INI);

    estado_t        estado_q, estado_d;
    logic [CDW-1:0] cd_q, cd_d;
    logic [9:0]     x_q, x_d;
    logic [9:0]     y_q, y_d;
    logic           ativa_q, ativa_d;
    logic           hit_q, hit_d;
    logic [1:0]     vidas_q, vidas_d;
    logic           fim_q, fim_d;
`ifdef MIRA_EN
    logic [9:0]     alvo_q, alvo_d;
`endif

    logic           tick_s;
    logic           colisao_s;
    logic [10:0]    y_passo_s;

    divisor_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_divisor (
        .clk   (CLOCK_50),
        .rst_n (reset),
        .srst  (reiniciarJogo),
        .pausa (pausa),
        .tick  (tick_s)
    );

    // Overlap test on 11-bit values so edge sums never wrap.
    always_comb begin
        colisao_s = ({1'b0, x_q} >= {1'b0, x_nave})
                 && ({1'b0, x_q} <  ({1'b0, x_nave} + {1'b0, largura_nave}))
                 && (({1'b0, y_q} + 11'(RAIO)) >= {1'b0, y_nave})
                 && ({1'b0, y_q} <  ({1'b0, y_nave} + {1'b0, altura_nave}));
        y_passo_s = {1'b0, y_q} + 11'(PASSO);
    end

    // Next-state, coordinate and lives logic; everything holds while paused.
    always_comb begin
        estado_d = estado_q;
        cd_d     = cd_q;
        x_d      = x_q;
        y_d      = y_q;
        ativa_d  = ativa_q;
        hit_d    = 1'b0;
        vidas_d  = vidas_q;
        fim_d    = fim_q;
`ifdef MIRA_EN
        alvo_d   = alvo_q;
`endif
        if (!pausa) begin
            case (estado_q)
                ESPERA: begin
                    if (tick_s) begin
                        if (cd_q < CD_MAX) begin
                            cd_d = cd_q + CDW'(1);
                        end else if (inimigo_vivo) begin
                            x_d      = centro(x_inimigo, largura_inimigo);
                            y_d      = y_inimigo + altura_inimigo;
                            ativa_d  = 1'b1;
                            cd_d     = '0;
                            estado_d = ATIVA;
`ifdef MIRA_EN
                            alvo_d   = centro(x_nave, largura_nave);
`endif
                        end else begin
                            cd_d = CD_MAX;
                        end
                    end else begin
                        cd_d = cd_q;
                    end
                end
                ATIVA: begin
                    // A hit takes priority over leaving the screen.
                    if (colisao_s) begin
                        estado_d = ACERTO;
                        ativa_d  = 1'b0;
                        x_d      = 10'd0;
                        y_d      = 10'd0;
                    end else if (tick_s) begin
                        if (y_passo_s >= 11'(Y_LIMITE)) begin
                            estado_d = ESPERA;
                            ativa_d  = 1'b0;
                            x_d      = 10'd0;
                            y_d      = 10'd0;
                            cd_d     = '0;
                        end else begin
                            y_d = y_passo_s[9:0];
`ifdef MIRA_EN
                            if (x_q < alvo_q) begin
                                x_d = x_q + 10'd1;
                            end else if (x_q > alvo_q) begin
                                x_d = x_q - 10'd1;
                            end else begin
                                x_d = x_q;
                            end
`endif
                        end
                    end else begin
                        y_d = y_q;
                    end
                end
                ACERTO: begin
                    hit_d   = 1'b1;
                    vidas_d = vidas_q - 2'd1;
                    if (vidas_q == 2'd1) begin
                        estado_d = FIM;
                        fim_d    = 1'b1;
                    end else begin
                        estado_d = ESPERA;
                        cd_d     = '0;
                    end
                end
                FIM: begin
                    ativa_d = 1'b0;
                end
                default: begin
                    estado_d = ESPERA;
                end
            endcase
        end else begin
            hit_d = 1'b0;
        end
    end

    // State and output registers: async reset, restart has top sync priority.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            estado_q <= ESPERA;
            cd_q     <= '0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            ativa_q  <= 1'b0;
            hit_q    <= 1'b0;
            vidas_q  <= VIDAS_RST;
            fim_q    <= 1'b0;
`ifdef MIRA_EN
            alvo_q   <= 10'd0;
`endif
        end else if (reiniciarJogo) begin
            estado_q <= ESPERA;
            cd_q     <= '0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            ativa_q  <= 1'b0;
            hit_q    <= 1'b0;
            vidas_q  <= VIDAS_RST;
            fim_q    <= 1'b0;
`ifdef MIRA_EN
            alvo_q   <= 10'd0;
`endif
        end else begin
            estado_q <= estado_d;
            cd_q     <= cd_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ativa_q  <= ativa_d;
            hit_q    <= hit_d;
            vidas_q  <= vidas_d;
            fim_q    <= fim_d;
`ifdef MIRA_EN
            alvo_q   <= alvo_d;
`endif
        end
    end

    assign x_bola_inimiga    = x_q;
    assign y_bola_inimiga    = y_q;
    assign raio_bola_inimiga = 10'(RAIO);
    assign bola_ativa        = ativa_q;
    assign nave_atingida     = hit_q;
    assign vidas             = vidas_q;
    assign fim_de_jogo       = fim_q;

endmodule

// File: tb/tb_disparo_inimigo.sv
// Directed table-driven bench for disparo_inimigo (TICK_DIV=4, COOLDOWN=2,
// PASSO=2). Vectors are applied at the falling edge and sampled after a
// given number of cycles; async reset and game-over windows are hand checked.
module tb_disparo_inimigo;

    logic       clk = 1'b0;
    logic       reset, pausa, reiniciarJogo, inimigo_vivo;
    logic [9:0] x_inimigo, y_inimigo, largura_inimigo, altura_inimigo;
    logic [9:0] x_nave, y_nave, largura_nave, altura_nave;
    logic [9:0] x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga;
    logic       bola_ativa, nave_atingida, fim_de_jogo;
    logic [1:0] vidas;

    int applied = 0;
    int miscompares = 0;
    int hit_count = 0;
    int act_count = 0;
    int act0;

    always #5 clk = ~clk;

    disparo_inimigo #(
        .TICK_DIV (4), .PASSO (2), .COOLDOWN (2),
        .RAIO (5), .Y_LIMITE (480), .VIDAS_INI (3)
    ) dut (
        .CLOCK_50          (clk),
        .reset             (reset),
        .pausa             (pausa),
        .reiniciarJogo     (reiniciarJogo),
        .inimigo_vivo      (inimigo_vivo),
        .x_inimigo         (x_inimigo),
        .y_inimigo         (y_inimigo),
        .largura_inimigo   (largura_inimigo),
        .altura_inimigo    (altura_inimigo),
        .x_nave            (x_nave),
        .y_nave            (y_nave),
        .largura_nave      (largura_nave),
        .altura_nave       (altura_nave),
        .x_bola_inimiga    (x_bola_inimiga),
        .y_bola_inimiga    (y_bola_inimiga),
        .raio_bola_inimiga (raio_bola_inimiga),
        .bola_ativa        (bola_ativa),
        .nave_atingida     (nave_atingida),
        .vidas             (vidas),
        .fim_de_jogo       (fim_de_jogo)
    );

    // Count hit pulses and active-ball cycles for window checks.
    always @(negedge clk) begin
        if (nave_atingida) hit_count++;
        if (bola_ativa) act_count++;
    end

    typedef struct {
        int         ncyc;
        logic       srst;
        logic       pausa;
        logic       vivo;
        logic [9:0] xn;
        logic [9:0] yn;
        logic       e_bola;
        logic [9:0] e_x;
        logic [9:0] e_y;
        logic [1:0] e_vidas;
        logic       e_fim;
        logic       e_hit;
    } vec_t;

    vec_t tabela[$];

    task automatic add(input int n, input logic s, input logic p, input logic v,
                       input int xn, input int yn, input logic b, input int ex,
                       input int ey, input int ev, input logic f, input logic h);
        vec_t r;
        r.ncyc = n; r.srst = s; r.pausa = p; r.vivo = v;
        r.xn = 10'(xn); r.yn = 10'(yn); r.e_bola = b;
        r.e_x = 10'(ex); r.e_y = 10'(ey); r.e_vidas = 2'(ev);
        r.e_fim = f; r.e_hit = h;
        tabela.push_back(r);
    endtask

    task automatic chk(input string nome, input int act, input int exp);
        applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nome, act, exp);
        end
    endtask

    task automatic aplica(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            pausa         = tabela[i].pausa;
            inimigo_vivo  = tabela[i].vivo;
            x_nave        = tabela[i].xn;
            y_nave        = tabela[i].yn;
            reiniciarJogo = tabela[i].srst;
            repeat (tabela[i].ncyc) @(negedge clk);
            reiniciarJogo = 1'b0;
            chk($sformatf("v%0d bola", i),  int'(bola_ativa),     int'(tabela[i].e_bola));
            chk($sformatf("v%0d x", i),     int'(x_bola_inimiga), int'(tabela[i].e_x));
            chk($sformatf("v%0d y", i),     int'(y_bola_inimiga), int'(tabela[i].e_y));
            chk($sformatf("v%0d vidas", i), int'(vidas),          int'(tabela[i].e_vidas));
            chk($sformatf("v%0d fim", i),   int'(fim_de_jogo),    int'(tabela[i].e_fim));
            chk($sformatf("v%0d hit", i),   int'(nave_atingida),  int'(tabela[i].e_hit));
        end
    endtask

    initial begin
        // Launch, pause mid-flight, fall to the bottom and retire (ship far away).
        add( 11, 0, 0, 1, 300, 400, 0,  0,   0, 3, 0, 0); // 0
        add(  1, 0, 0, 1, 300, 400, 1, 40,  60, 3, 0, 0); // 1 third tick launches
        add(  3, 0, 0, 1, 300, 400, 1, 40,  60, 3, 0, 0); // 2
        add(  1, 0, 0, 1, 300, 400, 1, 40,  62, 3, 0, 0); // 3 first step
        add( 20, 0, 1, 1, 300, 400, 1, 40,  62, 3, 0, 0); // 4 paused
        add(832, 0, 0, 1, 300, 400, 1, 40, 478, 3, 0, 0); // 5
        add(  3, 0, 0, 1, 300, 400, 1, 40, 478, 3, 0, 0); // 6
        add(  1, 0, 0, 1, 300, 400, 0,  0,   0, 3, 0, 0); // 7 retired, no life lost
        // Restart, three hits on a ship at (30,100) 40x20.
        add(  1, 1, 0, 1,  30, 100, 0,  0,   0, 3, 0, 0); // 8 restart
        add( 11, 0, 0, 1,  30, 100, 0,  0,   0, 3, 0, 0); // 9
        add(  1, 0, 0, 1,  30, 100, 1, 40,  60, 3, 0, 0); // 10
        add( 72, 0, 0, 1,  30, 100, 1, 40,  96, 3, 0, 0); // 11 y+5 reaches 101
        add(  1, 0, 0, 1,  30, 100, 0,  0,   0, 3, 0, 0); // 12 collision
        add(  1, 0, 0, 1,  30, 100, 0,  0,   0, 2, 0, 1); // 13 pulse, life lost
        add(  1, 0, 0, 1,  30, 100, 0,  0,   0, 2, 0, 0); // 14 pulse ends
        add(  9, 0, 0, 1,  30, 100, 1, 40,  60, 2, 0, 0); // 15 relaunch
        add( 73, 0, 0, 1,  30, 100, 0,  0,   0, 2, 0, 0); // 16 second collision
        add(  1, 0, 0, 1,  30, 100, 0,  0,   0, 1, 0, 1); // 17
        add( 84, 0, 0, 1,  30, 100, 0,  0,   0, 0, 1, 1); // 18 game over
        add(  1, 0, 0, 1,  30, 100, 0,  0,   0, 0, 1, 0); // 19
        add(200, 0, 0, 1,  30, 100, 0,  0,   0, 0, 1, 0); // 20 50 ticks in FIM
        add(  1, 1, 0, 1,  30, 100, 0,  0,   0, 3, 0, 0); // 21 restart
        add( 86, 0, 0, 1,  30, 100, 0,  0,   0, 2, 0, 1); // 22
        add( 14, 0, 0, 1,  30, 100, 1, 40,  62, 2, 0, 0); // 23 mid-flight
        // After async reset: enemy dead, cooldown saturates, then fires on next tick.
        add( 40, 0, 0, 0,  30, 100, 0,  0,   0, 3, 0, 0); // 24
        add(  3, 0, 0, 1,  30, 100, 0,  0,   0, 3, 0, 0); // 25
        add(  1, 0, 0, 1,  30, 100, 1, 40,  60, 3, 0, 0); // 26

        reset = 1'b0; pausa = 1'b0; reiniciarJogo = 1'b0; inimigo_vivo = 1'b1;
        x_inimigo = 10'd20; y_inimigo = 10'd40; largura_inimigo = 10'd40; altura_inimigo = 10'd20;
        x_nave = 10'd300; y_nave = 10'd400; largura_nave = 10'd40; altura_nave = 10'd20;

        repeat (3) @(negedge clk);
        chk("rst bola",  int'(bola_ativa),        0);
        chk("rst x",     int'(x_bola_inimiga),    0);
        chk("rst y",     int'(y_bola_inimiga),    0);
        chk("rst vidas", int'(vidas),             3);
        chk("rst fim",   int'(fim_de_jogo),       0);
        chk("rst hit",   int'(nave_atingida),     0);
        chk("rst raio",  int'(raio_bola_inimiga), 5);
        reset = 1'b1;

        aplica(0, 7);
        chk("miss no hit pulse", hit_count, 0);
        aplica(8, 19);
        chk("three hit pulses", hit_count, 3);
        act0 = act_count;
        aplica(20, 20);
        chk("no launch in FIM", act_count - act0, 0);
        aplica(21, 23);

        // Asynchronous reset between clock edges.
        #2 reset = 1'b0;
        #1;
        chk("async bola",  int'(bola_ativa),        0);
        chk("async x",     int'(x_bola_inimiga),    0);
        chk("async y",     int'(y_bola_inimiga),    0);
        chk("async vidas", int'(vidas),             3);
        chk("async raio",  int'(raio_bola_inimiga), 5);
        @(negedge clk);
        reset = 1'b1;
        aplica(24, 26);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
